// File: rtl/cr_had_duc_pkg.sv
// Shared HAD definitions: controller state encodings and the instruction words
// injected into the pipeline by the upload and download controllers.
package cr_had_duc_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR_WAIT = 4'd1;
    localparam logic [3:0] ST_ADDR_LD   = 4'd2;
    localparam logic [3:0] ST_ADDR_RTR  = 4'd3;
    localparam logic [3:0] ST_LW_LD     = 4'd4;
    localparam logic [3:0] ST_LW_WAIT   = 4'd5;
    localparam logic [3:0] ST_DATA_HOLD = 4'd6;
    localparam logic [3:0] ST_ADDR_GEN  = 4'd7;
    localparam logic [3:0] ST_GEN_WAIT  = 4'd8;

    localparam logic [31:0] INST_MV_X1     = 32'h0000_8093;  // mv   x1,x1
    localparam logic [31:0] INST_LW_X2     = 32'h0000_A103;  // lw   x2,0(x1)
    localparam logic [31:0] INST_ADDI_X1_4 = 32'h0040_8093;  // addi x1,x1,4

    // States in which an instruction is presented to the IU.
    function automatic logic is_inject_state(input logic [3:0] st);
        return (st == ST_ADDR_LD) || (st == ST_LW_LD) || (st == ST_ADDR_GEN);
    endfunction

endpackage

// File: rtl/cr_had_duc.sv
// HAD upload controller: loads a base address, then streams memory words to the
// host by injecting mv/lw/addi instructions into the pipeline.
module cr_had_duc
    import cr_had_duc_pkg::*;
(
    input  logic        cpuclk,
    input  logic        hadrst,
    input  logic        regs_xx_duc_en,
    input  logic        jtag_xx_update_dr,
    input  logic        jtag_xx_capture_dr,
    input  logic        regs_duc_daddr_sel,
    input  logic        regs_duc_ddata_sel,
    input  logic        iu_had_xx_retire,
    input  logic [31:0] iu_had_xx_wb_data,
    output logic        duc_regs_update_ir,
    output logic        duc_regs_update_csr,
    output logic        duc_regs_ffy,
    output logic [31:0] duc_regs_ir,
    output logic [31:0] duc_regs_ddata,
    output logic        duc_regs_ddata_vld,
    output logic [15:0] duc_regs_word_cnt,
    output logic        duc_regs_busy
);

    logic [3:0]  state_q, state_d;
    logic [31:0] ddata_q, ddata_d;
    logic        vld_q, vld_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic        addr_ready;
    logic        data_taken;

    assign addr_ready = jtag_xx_update_dr & regs_duc_daddr_sel;
    assign data_taken = jtag_xx_capture_dr & regs_duc_ddata_sel;

    always_comb begin
        state_d    = state_q;
        ddata_d    = ddata_q;
        vld_d      = vld_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            ST_IDLE:      if (regs_xx_duc_en) state_d = ST_ADDR_WAIT;
            ST_ADDR_WAIT: begin
                if (addr_ready)           state_d = ST_ADDR_LD;
                else if (!regs_xx_duc_en) state_d = ST_IDLE;
            end
            ST_ADDR_LD:   state_d = ST_ADDR_RTR;
            ST_ADDR_RTR:  if (iu_had_xx_retire) state_d = ST_LW_LD;
            ST_LW_LD:     state_d = ST_LW_WAIT;
            ST_LW_WAIT: begin
                if (iu_had_xx_retire) begin
                    ddata_d    = iu_had_xx_wb_data;
                    vld_d      = 1'b1;
                    word_cnt_d = word_cnt_q + 16'd1;
                    state_d    = ST_DATA_HOLD;
                end
            end
            ST_DATA_HOLD: begin
                // A new base wins over a simultaneous capture; the held word is consumed either way.
                if (addr_ready) begin
                    state_d = ST_ADDR_LD;
                    vld_d   = 1'b0;
                end else if (data_taken) begin
                    state_d = ST_ADDR_GEN;
                    vld_d   = 1'b0;
                end else if (!regs_xx_duc_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR_GEN:  state_d = ST_GEN_WAIT;
            ST_GEN_WAIT: begin
                if (iu_had_xx_retire) state_d = regs_xx_duc_en ? ST_LW_LD : ST_IDLE;
            end
            default:      state_d = ST_IDLE;
        endcase
        if (state_d == ST_ADDR_LD) word_cnt_d = 16'd0;
        if (state_d == ST_IDLE)    vld_d      = 1'b0;
    end

    always_ff @(posedge cpuclk) begin
        if (hadrst) begin
            state_q    <= ST_IDLE;
            ddata_q    <= 32'd0;
            vld_q      <= 1'b0;
            word_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            ddata_q    <= ddata_d;
            vld_q      <= vld_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    always_comb begin
        duc_regs_ir = 32'd0;
        case (state_q)
            ST_ADDR_LD:  duc_regs_ir = INST_MV_X1;
            ST_LW_LD:    duc_regs_ir = INST_LW_X2;
            ST_ADDR_GEN: duc_regs_ir = INST_ADDI_X1_4;
            default:     duc_regs_ir = 32'd0;
        endcase
    end

    assign duc_regs_update_ir  = is_inject_state(state_q);
    assign duc_regs_update_csr = is_inject_state(state_q);
    assign duc_regs_ffy        = (state_q == ST_ADDR_LD);
    assign duc_regs_busy       = (state_q != ST_IDLE);
    assign duc_regs_ddata      = ddata_q;
    assign duc_regs_ddata_vld  = vld_q;
    assign duc_regs_word_cnt   = word_cnt_q;

endmodule

// File: doc/cr_had_duc.md
CR_HAD_DUC -- requirements
Module: cr_had_duc

Interface
REQ-001 SHALL have ports: cpuclk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have hadrst  in  1  synchronous, active-high reset.
REQ-003 SHALL have regs_xx_duc_en  in  1  upload mode enable from HAD regs.
REQ-004 SHALL have jtag_xx_update_dr / jtag_xx_capture_dr  in  1 each  JTAG DR update / capture strobes, one cpuclk wide.
REQ-005 SHALL have regs_duc_daddr_sel / regs_duc_ddata_sel  in  1 each  DR currently targets DADDR / DDATA.
REQ-006 SHALL have iu_had_xx_retire  in  1  injected instruction retired this cycle.
REQ-007 SHALL have iu_had_xx_wb_data  in  32  write-back result of the retiring instruction.
REQ-008 SHALL have duc_regs_update_ir, duc_regs_update_csr, duc_regs_ffy  out  1 each; duc_regs_ir  out  32.
REQ-009 SHALL have duc_regs_ddata  out  32  last word read; duc_regs_ddata_vld  out  1  word ready for host.
REQ-010 SHALL have duc_regs_word_cnt  out  16  words delivered since the last base load; duc_regs_busy  out  1  state != IDLE.

Function
REQ-011 SHALL define addr_ready = jtag_xx_update_dr & regs_duc_daddr_sel, and data_taken = jtag_xx_capture_dr & regs_duc_ddata_sel.
REQ-012 SHALL implement a state machine with states IDLE, ADDR_WAIT, ADDR_LD, ADDR_RTR, LW_LD, LW_WAIT, DATA_HOLD, ADDR_GEN, GEN_WAIT.
REQ-013 IDLE -> ADDR_WAIT when regs_xx_duc_en=1; otherwise remain in IDLE.
REQ-014 ADDR_WAIT: addr_ready -> ADDR_LD; else !en -> IDLE; else hold.
REQ-015 ADDR_LD: one cycle, then ADDR_RTR; SHALL drive ir=32'h00008093 (mv x1,x1) with ffy=1.
REQ-016 ADDR_RTR: retire -> LW_LD; otherwise hold.
REQ-017 LW_LD: one cycle, then LW_WAIT; SHALL drive ir=32'h0000A103 (lw x2,0(x1)) with ffy=0.
REQ-018 LW_WAIT: on retire, SHALL register iu_had_xx_wb_data into ddata, set ddata_vld, increment word_cnt (16-bit, wraps 0xFFFF->0), then go to DATA_HOLD.
REQ-019 DATA_HOLD priority: addr_ready -> ADDR_LD; else data_taken -> ADDR_GEN; else !en -> IDLE; else hold.
REQ-020 ddata_vld SHALL clear in the cycle after data_taken, addr_ready in DATA_HOLD, or entry to IDLE; ddata SHALL hold its value until the next lw retire.
REQ-021 Simultaneous addr_ready and data_taken in DATA_HOLD: the current word counts as consumed, the new base wins -> ADDR_LD, and word_cnt SHALL clear to 0.
REQ-022 ADDR_LD entry SHALL always clear word_cnt to 0.
REQ-023 ADDR_GEN: one cycle, then GEN_WAIT; SHALL drive ir=32'h00408093 (addi x1,x1,4) with ffy=0.
REQ-024 GEN_WAIT: on retire -> LW_LD if en, else IDLE; otherwise hold.
REQ-025 regs_xx_duc_en deassertion SHALL be ignored in ADDR_LD, ADDR_RTR, LW_LD, LW_WAIT and ADDR_GEN, so an in-flight instruction always completes first.
REQ-026 update_ir and update_csr SHALL be 1 exactly in ADDR_LD, LW_LD and ADDR_GEN, and 0 in all other states; ir SHALL be 0 outside these states.
REQ-027 All outputs SHALL be derived from registered state or registered data, with no combinational input-to-output path.
REQ-028 Unencoded state values SHALL go to IDLE on the next cycle.
REQ-029 retire asserted in any state other than ADDR_RTR, LW_WAIT or GEN_WAIT SHALL be ignored.

Reset
REQ-030 When hadrst=1 at a clock edge, the block SHALL enter IDLE and clear ddata to 0, ddata_vld to 0 and word_cnt to 0.
REQ-031 While in reset, busy, update_ir, update_csr and ffy SHALL be 0 and ir SHALL be 0.
REQ-032 Reset asserted mid-sequence SHALL abort immediately; any in-flight retire SHALL be ignored.

Structure
REQ-033 State encodings (4-bit) and the three instruction constants SHALL reside in a shared HAD package, also used by the download controller.
REQ-034 No sub-module is required; the state machine, data register and counter SHALL live in one module.

Verification
REQ-035 Base load: en=1, DADDR update with 0x2000_0000 -> ir=0x00008093 with ffy=1 for 1 cycle; after retire, ir=0x0000A103; retire with wb=0xDEAD_BEEF -> ddata=0xDEADBEEF, vld=1, word_cnt=1.
REQ-036 Streaming: 3 DDATA captures, each lw retire returning 0x11, 0x22, 0x33 -> an addi 0x00408093 inject between words, word_cnt=3, vld drops 1 cycle after each capture.
REQ-037 Collision: in DATA_HOLD, DADDR update and DDATA capture in the same cycle -> next state ADDR_LD, word_cnt=0, vld=0.
REQ-038 Late disable: en=0 while in LW_WAIT -> still captures wb data on retire, DATA_HOLD -> IDLE next cycle, vld clears.
REQ-039 Mid-operation reset: hadrst=1 in GEN_WAIT, retire the same cycle -> IDLE, all outputs 0, no LW_LD.
REQ-040 Wrap: preload word_cnt=0xFFFF via 65535 streamed words, one more word -> word_cnt=0x0000.
